// File: rtl/mem_stage_sb.sv
// Memory stage with a circular store buffer, store-to-load forwarding and a
// single-outstanding bus master (IDLE / ST_BUS / LD_BUS).

// Per-entry address compare: hit on same word, covered when every byte the
// load needs is present in the entry's strobe.
module sb_match #(
    parameter int XLEN = 32
) (
    input  logic              ent_vld,
    input  logic [XLEN-3:0]   ent_addr,
    input  logic [XLEN/8-1:0] ent_strb,
    input  logic [XLEN-3:0]   ld_addr,
    input  logic [XLEN/8-1:0] ld_need,
    output logic              hit,
    output logic              covered
);
    assign hit     = ent_vld && (ent_addr == ld_addr);
    assign covered = ((ent_strb & ld_need) == ld_need);
endmodule

module mem_stage_sb #(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [2:0]        i_f3,
    input  logic              i_mem_write,
    input  logic              i_mem_read,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wr_data,
    output logic [XLEN-1:0]   o_rd,
    output logic              o_rd_valid,
    output logic              o_stall,
    output logic              o_ex_ld,
    output logic              o_ex_st,
    output logic              o_sb_empty,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    input  logic              i_mem_ack,
    input  logic [XLEN-1:0]   i_mem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = XLEN - 2;
    localparam logic [CW-1:0] FULL = CW'(SB_DEPTH);

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic [NB-1:0]   strb;
    } sb_ent_t;

    typedef enum logic [1:0] {IDLE, ST_BUS, LD_BUS} state_t;

    state_t          state, state_nx;
    sb_ent_t         sb_q [SB_DEPTH];
    logic [PW-1:0]   head, tail, idx;
    logic [CW-1:0]   count;
    logic            quiet_q;
    logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
    logic [NB-1:0]   mem_wstrb_q;

    logic            quiet, f3_ok_ld, f3_ok_st, mis, ld_ok, st_ok;
    logic            push, pop, ld_mem, fwd, ld_done, any_hit, y_cov;
    logic [NB-1:0]   need;
    logic [XLEN-1:0] st_data, y_data;
    logic [SB_DEPTH-1:0] ent_vld, hit, cov;

    // Lane select then sign/zero extension according to funct3.
    function automatic logic [XLEN-1:0] ld_ext(input logic [XLEN-1:0] w,
                                               input logic [1:0] a,
                                               input logic [2:0] f3);
        logic [XLEN-1:0] s;
        s = w >> {a, 3'b000};
        case (f3[1:0])
            2'b00:   ld_ext = f3[2] ? {{(XLEN-8){1'b0}}, s[7:0]}
                                    : {{(XLEN-8){s[7]}}, s[7:0]};
            2'b01:   ld_ext = f3[2] ? {{(XLEN-16){1'b0}}, s[15:0]}
                                    : {{(XLEN-16){s[15]}}, s[15:0]};
            default: ld_ext = s;
        endcase
    endfunction

    // The cycle after reset stays silent: no request is accepted or reported.
    assign quiet = !i_rst || quiet_q;

    // Access decode, alignment and byte-lane masks.
    always_comb begin
        f3_ok_ld = i_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        f3_ok_st = i_f3 inside {3'b000, 3'b001, 3'b010};
        mis      = ((i_f3[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_f3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        case (i_f3[1:0])
            2'b00:   need = NB'(1) << i_addr[1:0];
            2'b01:   need = NB'(3) << i_addr[1:0];
            default: need = '1;
        endcase
        st_data = i_wr_data << {i_addr[1:0], 3'b000};
    end

    assign o_ex_ld = i_valid && i_mem_read  && (!f3_ok_ld || mis);
    assign o_ex_st = i_valid && i_mem_write && (!f3_ok_st || mis);
    assign ld_ok   = i_valid && !quiet && i_mem_read  && f3_ok_ld && !mis;
    assign st_ok   = i_valid && !quiet && i_mem_write && f3_ok_st && !mis;

    for (genvar g = 0; g < SB_DEPTH; g++) begin : g_ent
        logic [PW-1:0] age;
        assign age        = PW'(g) - head;
        assign ent_vld[g] = {1'b0, age} < count;
        sb_match #(.XLEN(XLEN)) u_match (
            .ent_vld  (ent_vld[g]),
            .ent_addr (sb_q[g].addr),
            .ent_strb (sb_q[g].strb),
            .ld_addr  (i_addr[XLEN-1:2]),
            .ld_need  (need),
            .hit      (hit[g]),
            .covered  (cov[g])
        );
    end

    // Walk oldest to youngest so the last hit seen is the youngest match.
    always_comb begin
        any_hit = 1'b0;
        y_cov   = 1'b0;
        y_data  = '0;
        idx     = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = head + PW'(k);
            if (hit[idx]) begin
                any_hit = 1'b1;
                y_cov   = cov[idx];
                y_data  = sb_q[idx].data;
            end
        end
    end

    assign fwd     = ld_ok && any_hit && y_cov;
    assign ld_mem  = ld_ok && !any_hit;
    assign ld_done = (state == LD_BUS) && i_mem_ack;
    assign push    = st_ok && (count != FULL);
    assign pop     = (state == ST_BUS) && i_mem_ack;

    // Load result, forwarding and stall generation.
    always_comb begin
        o_rd_valid = 1'b0;
        o_rd       = '0;
        o_stall    = 1'b0;
        if (!quiet) begin
            if (ld_done) begin
                o_rd_valid = 1'b1;
                o_rd       = ld_ext(i_mem_rdata, i_addr[1:0], i_f3);
            end else if (fwd) begin
                o_rd_valid = 1'b1;
                o_rd       = ld_ext(y_data, i_addr[1:0], i_f3);
            end else if (ld_ok) begin
                o_stall = 1'b1;
            end else if (st_ok && (count == FULL)) begin
                o_stall = 1'b1;
            end
        end
    end

    // Bus FSM next state: pending loads win over draining.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (ld_mem)              state_nx = LD_BUS;
                else if (count != '0)    state_nx = ST_BUS;
            end
            ST_BUS:  if (i_mem_ack) state_nx = IDLE;
            LD_BUS:  if (i_mem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, pointers, count and the held bus request fields.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            quiet_q     <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            quiet_q <= 1'b0;
            state   <= state_nx;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (state == IDLE && state_nx == ST_BUS) begin
                mem_addr_q  <= {sb_q[head].addr, 2'b00};
                mem_wdata_q <= sb_q[head].data;
                mem_wstrb_q <= sb_q[head].strb;
            end else if (state == IDLE && state_nx == LD_BUS) begin
                mem_addr_q  <= {i_addr[XLEN-1:2], 2'b00};
                mem_wdata_q <= '0;
                mem_wstrb_q <= '0;
            end
        end
    end

    // Entry storage; validity lives in head/count so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (push) sb_q[tail] <= '{addr: i_addr[XLEN-1:2], data: st_data, strb: need};
    end

    assign o_mem_req   = i_rst && (state != IDLE);
    assign o_mem_we    = o_mem_req && (state == ST_BUS);
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wstrb = mem_wstrb_q;
    assign o_sb_empty  = !i_rst || ((count == '0) && (state != ST_BUS));
endmodule

// File: tb/tb_mem_stage_sb.sv
// Scoreboard bench for mem_stage_sb: the reference is a byte-addressed
// architectural memory updated in program order; every load's expected
// value is queued at issue and compared when the DUT reports o_rd_valid.
module tb_mem_stage_sb;
    logic        i_clk = 0, i_rst = 0, i_valid = 0, i_mem_write = 0, i_mem_read = 0;
    logic        i_mem_ack = 0;
    logic [2:0]  i_f3 = 0;
    logic [31:0] i_addr = 0, i_wr_data = 0, i_mem_rdata = 0;
    logic [31:0] o_rd, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        o_rd_valid, o_stall, o_ex_ld, o_ex_st, o_sb_empty, o_mem_req, o_mem_we;

    int          n_chk = 0, n_pass = 0;
    logic [7:0]  arch [0:1023];
    logic [7:0]  dram [0:1023];
    logic [31:0] exp_q [$];
    int          lat = 0, rd_cnt = 0, wait_cnt = 0;
    bit          hold_ack = 0, prev_ack = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;

    mem_stage_sb #(.XLEN(32), .SB_DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_f3(i_f3),
        .i_mem_write(i_mem_write), .i_mem_read(i_mem_read), .i_addr(i_addr),
        .i_wr_data(i_wr_data), .o_rd(o_rd), .o_rd_valid(o_rd_valid),
        .o_stall(o_stall), .o_ex_ld(o_ex_ld), .o_ex_st(o_ex_st),
        .o_sb_empty(o_sb_empty), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic void arch_store(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] d);
        for (int i = 0; i < size_of(f3); i++) arch[(a + i) & 1023] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 0;
        for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = arch[(a + i) & 1023];
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // Memory responder: acks after lat wait cycles, checks request hygiene.
    always @(posedge i_clk) begin
        #1;
        if (prev_ack) chk("gap_after_ack", {31'b0, o_mem_req}, 32'd0);
        prev_ack = 0;
        if (o_mem_req) begin
            if (wait_cnt == 0) begin
                cap_addr = o_mem_addr; cap_wdata = o_mem_wdata; cap_strb = o_mem_wstrb;
                chk("bus_addr_aligned", {30'b0, o_mem_addr[1:0]}, 32'd0);
            end
            if (!hold_ack && wait_cnt >= lat) begin
                if (wait_cnt > 0) begin
                    chk("bus_addr_stable", o_mem_addr, cap_addr);
                    chk("bus_wdata_stable", o_mem_wdata, cap_wdata);
                    chk("bus_wstrb_stable", {28'b0, o_mem_wstrb}, {28'b0, cap_strb});
                end
                i_mem_ack = 1; prev_ack = 1; wait_cnt = 0;
                if (o_mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (o_mem_wstrb[b]) dram[(o_mem_addr + b) & 1023] = o_mem_wdata[8*b +: 8];
                    i_mem_rdata = $urandom;
                end else begin
                    for (int b = 0; b < 4; b++) i_mem_rdata[8*b +: 8] = dram[(o_mem_addr + b) & 1023];
                    rd_cnt++;
                end
            end else begin
                i_mem_ack = 0; wait_cnt++;
            end
        end else begin
            i_mem_ack = 0; wait_cnt = 0; i_mem_rdata = $urandom;
        end
    end

    // Scoreboard monitor.
    always @(negedge i_clk) begin
        if (i_rst && o_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("rd_valid_spurious", {31'b0, o_rd_valid}, 32'd0);
            else chk("load_data", o_rd, exp_q.pop_front());
        end
    end

    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int cyc, output logic [31:0] rd);
        bit ill, ex;
        ill = st ? !(f3 inside {3'b000, 3'b001, 3'b010})
                 : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        ex  = ill || ((a % size_of(f3)) != 0);
        i_valid = 1; i_mem_write = st; i_mem_read = !st; i_f3 = f3; i_addr = a; i_wr_data = d;
        if (!ex) begin
            if (st) arch_store(f3, a, d);
            else exp_q.push_back(ref_load(f3, a));
        end
        @(negedge i_clk);
        chk("ex_ld", {31'b0, o_ex_ld}, {31'b0, !st && ex});
        chk("ex_st", {31'b0, o_ex_st}, {31'b0, st && ex});
        cyc = 0;
        while (o_stall === 1'b1 && cyc < 300) begin @(negedge i_clk); cyc++; end
        chk("stall_release", {31'b0, o_stall}, 32'd0);
        chk("rd_valid", {31'b0, o_rd_valid}, {31'b0, !st && !ex});
        rd = o_rd;
        @(posedge i_clk); #1;
        i_valid = 0; i_mem_write = 0; i_mem_read = 0;
    endtask

    task automatic wait_empty();
        int k = 0;
        @(negedge i_clk);
        while (o_sb_empty !== 1'b1 && k < 500) begin @(negedge i_clk); k++; end
        chk("drain", {31'b0, o_sb_empty}, 32'd1);
        @(posedge i_clk); #1;
    endtask

    initial begin
        int cyc, r0, k;
        logic [31:0] rd, a;
        logic [2:0] f3;
        bit st;
        for (int i = 0; i < 1024; i++) begin arch[i] = 8'($urandom); dram[i] = arch[i]; end

        // Reset with a load presented: everything must stay quiet.
        i_valid = 1; i_mem_read = 1; i_f3 = 3'b010; i_addr = 32'h100;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req", {31'b0, o_mem_req}, 32'd0);
        chk("rst_rd_valid", {31'b0, o_rd_valid}, 32'd0);
        chk("rst_stall", {31'b0, o_stall}, 32'd0);
        chk("rst_rd", o_rd, 32'd0);
        chk("rst_sb_empty", {31'b0, o_sb_empty}, 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1; i_valid = 0; i_mem_read = 0;
        @(negedge i_clk);
        chk("post_rst_req", {31'b0, o_mem_req}, 32'd0);
        chk("post_rst_stall", {31'b0, o_stall}, 32'd0);
        chk("post_rst_rd", o_rd, 32'd0);
        chk("post_rst_sb_empty", {31'b0, o_sb_empty}, 32'd1);
        @(posedge i_clk); #1;

        // Store then forward.
        lat = 0; r0 = rd_cnt;
        issue(1, 3'b010, 32'h100, 32'hDEAD_BEEF, cyc, rd);
        issue(0, 3'b010, 32'h100, 32'h0, cyc, rd);
        chk("fwd_no_stall", cyc, 0);
        chk("fwd_rd", rd, 32'hDEAD_BEEF);
        chk("fwd_no_bus_read", rd_cnt, r0);
        wait_empty();

        // Partial forward: drain then read.
        for (int i = 0; i < 4; i++) begin arch[32'h200 + i] = 0; dram[32'h200 + i] = 0; end
        lat = 1; r0 = rd_cnt;
        issue(1, 3'b000, 32'h203, 32'h0000_007F, cyc, rd);
        issue(0, 3'b010, 32'h200, 32'h0, cyc, rd);
        chk("partial_stalled", {31'b0, cyc > 0}, 32'd1);
        chk("partial_rd", rd, 32'h7F00_0000);
        chk("partial_bus_read", rd_cnt, r0 + 1);
        wait_empty();

        // Full buffer.
        hold_ack = 1; lat = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1, 3'b010, 32'h110 + 32'(i * 4), $urandom, cyc, rd);
            chk("fill_no_stall", cyc, 0);
        end
        i_valid = 1; i_mem_write = 1; i_mem_read = 0; i_f3 = 3'b010;
        i_addr = 32'h120; i_wr_data = $urandom;
        arch_store(3'b010, i_addr, i_wr_data);
        @(negedge i_clk); chk("full_stall", {31'b0, o_stall}, 32'd1);
        repeat (2) begin @(negedge i_clk); chk("full_hold", {31'b0, o_stall}, 32'd1); end
        hold_ack = 0;
        @(negedge i_clk); chk("pop_not_admit", {31'b0, o_stall}, 32'd1);
        @(negedge i_clk); chk("admit_after_ack", {31'b0, o_stall}, 32'd0);
        @(posedge i_clk); #1; i_valid = 0; i_mem_write = 0;
        wait_empty();

        // Misalignment.
        issue(0, 3'b001, 32'h101, 32'h0, cyc, rd);
        @(negedge i_clk); chk("mis_no_req", {31'b0, o_mem_req}, 32'd0);
        @(posedge i_clk); #1;
        issue(1, 3'b010, 32'h102, 32'h1234_5678, cyc, rd);
        @(negedge i_clk); chk("mis_sb_empty", {31'b0, o_sb_empty}, 32'd1);
        @(posedge i_clk); #1;

        // Extension from memory, ack latency 3.
        {dram[32'h103], dram[32'h102], dram[32'h101], dram[32'h100]} = 32'h0000_80F0;
        {arch[32'h103], arch[32'h102], arch[32'h101], arch[32'h100]} = 32'h0000_80F0;
        lat = 3;
        issue(0, 3'b000, 32'h100, 32'h0, cyc, rd);
        chk("lb_latency", cyc, 4);
        chk("lb_sext", rd, 32'hFFFF_FFF0);
        issue(0, 3'b101, 32'h100, 32'h0, cyc, rd);
        chk("lhu_latency", cyc, 4);
        chk("lhu_zext", rd, 32'h0000_80F0);

        // Randomized mix.
        for (int n = 0; n < 400; n++) begin
            lat = $urandom_range(0, 3);
            k = $urandom_range(0, 9);
            if (k == 0) begin
                @(posedge i_clk); #1;
            end else begin
                st = (k < 5);
                if ($urandom_range(0, 9) < 8)
                    f3 = st ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 1) % 5 == 3 ? 4 : ($urandom_range(0, 4) > 2 ? $urandom_range(4, 5) : $urandom_range(0, 2)));
                else f3 = 3'($urandom);
                a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f3) - 1);
                issue(st, f3, a, $urandom, cyc, rd);
            end
        end
        wait_empty();

        // Reset mid-drain discards the store in flight.
        hold_ack = 1; lat = 0;
        issue(1, 3'b010, 32'h300, 32'h1234_5678, cyc, rd);
        k = 0;
        @(negedge i_clk);
        while (!(o_mem_req === 1'b1 && o_mem_we === 1'b1) && k < 20) begin @(negedge i_clk); k++; end
        chk("drain_started", {31'b0, o_mem_we}, 32'd1);
        @(posedge i_clk); #1; i_rst = 0;
        @(posedge i_clk); #1; i_rst = 1;
        @(negedge i_clk);
        chk("rst_mid_req", {31'b0, o_mem_req}, 32'd0);
        chk("rst_mid_sb_empty", {31'b0, o_sb_empty}, 32'd1);
        hold_ack = 0; lat = 1;
        for (int i = 0; i < 1024; i++) arch[i] = dram[i];
        @(posedge i_clk); #1;
        r0 = rd_cnt;
        issue(0, 3'b010, 32'h300, 32'h0, cyc, rd);
        chk("post_rst_bus_read", rd_cnt, r0 + 1);

        wait_empty();
        repeat (3) @(negedge i_clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stage_sb.md
MEM_STAGE_SB -- requirements
Module: mem_stage_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have parameter SB_DEPTH, default 4, store-buffer entries; power of two, at least 2.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1  memory-stage instruction valid.
REQ-006 SHALL have port i_f3  input  3  funct3 (access size and sign).
REQ-007 SHALL have ports i_mem_write / i_mem_read  input  1 each  store / load request.
REQ-008 SHALL have port i_addr  input  XLEN  effective address.
REQ-009 SHALL have port i_wr_data  input  XLEN  store data, right-aligned.
REQ-010 SHALL have port o_rd  output  XLEN  extended load result.
REQ-011 SHALL have port o_rd_valid  output  1  o_rd valid this cycle.
REQ-012 SHALL have port o_stall  output  1  pipeline must hold all inputs.
REQ-013 SHALL have ports o_ex_ld / o_ex_st  output  1 each  misaligned or illegal-f3 load / store.
REQ-014 SHALL have port o_sb_empty  output  1  store buffer empty and no store on the bus.
REQ-015 SHALL have ports o_mem_req, o_mem_we  output  1 each, o_mem_addr  output  XLEN (word-aligned), o_mem_wdata  output  XLEN, o_mem_wstrb  output  XLEN/8  memory request.
REQ-016 SHALL have ports i_mem_ack  input  1, i_mem_rdata  input  XLEN  memory response.

Function
REQ-017 SHALL decode f3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; any other f3, or f3 100/101 on a store, is illegal.
REQ-018 SHALL assert o_ex_ld/o_ex_st combinationally when i_valid is high and the access is illegal, or halfword with addr[0]=1, or word with addr[1:0]!=0. Such an access causes no enqueue, no bus request, and no stall.
REQ-019 SHALL hold a circular FIFO of SB_DEPTH entries {word address, lane-shifted data, strobe}, tracked by head/tail pointers and a count; pointers wrap modulo SB_DEPTH.
REQ-020 SHALL enqueue a legal store in the cycle it is presented when count<SB_DEPTH, with o_stall=0. When count==SB_DEPTH, o_stall=1 until count<SB_DEPTH at a clock edge; a pop in the same cycle does not admit the store.
REQ-021 SHALL use an FSM with states IDLE, ST_BUS and LD_BUS. o_mem_req=1 exactly while in ST_BUS or LD_BUS, and address, data and strobe are held stable until i_mem_ack.
REQ-022 SHALL move IDLE->LD_BUS when a load needs memory (REQ-024). Otherwise it SHALL move IDLE->ST_BUS when count>0, issuing the head entry with o_mem_we=1. Loads take priority over draining.
REQ-023 SHALL, in ST_BUS, pop the head and return to IDLE on i_mem_ack. In LD_BUS it SHALL drive o_rd, assert o_rd_valid and o_stall=0 in the i_mem_ack cycle, then return to IDLE.
REQ-024 SHALL, for a legal load, search all valid entries for the same word address:
- no match -> memory read;
- the youngest match's strobe covers every needed byte -> forward in the same cycle with o_rd_valid=1 and o_stall=0;
- partial coverage -> o_stall=1 until count==0, then memory read.
REQ-025 SHALL hold o_stall=1 for a load from its first cycle until the cycle it completes. A load arriving during ST_BUS waits for that ack before entering LD_BUS.
REQ-026 SHALL sign-extend LB/LH, zero-extend LBU/LHU, and select the byte or halfword lane with addr[1:0].
REQ-027 SHALL drive o_sb_empty = (count==0) and (state != ST_BUS).
REQ-028 SHALL never issue a new request in the cycle i_mem_ack is received; at least one IDLE cycle separates transactions.

Reset
REQ-029 SHALL, when i_rst=0 at a clock edge, clear count and pointers, enter IDLE, and discard buffered stores, including any store in flight; an in-flight transaction is abandoned.
REQ-030 SHALL drive o_mem_req=0, o_rd_valid=0, o_stall=0, o_rd=0 and o_sb_empty=1 while in reset and in the first cycle after it.

Verification
REQ-031 SHALL be verified for store-then-forward: SW 0xDEADBEEF to 0x100, then LW 0x100 next cycle -> o_rd=0xDEADBEEF, o_rd_valid=1 in that cycle, o_stall=0, no read on the bus.
REQ-032 SHALL be verified for partial forward: SB 0x7F to 0x203, then LW 0x200 -> o_stall=1 until the buffer drains, then a bus read; with memory 0x7F000000 returned, o_rd=0x7F000000.
REQ-033 SHALL be verified for a full buffer: SB_DEPTH+1 back-to-back SW with i_mem_ack held 0 -> o_stall=1 on the 5th store only; the first ack admits it one cycle later.
REQ-034 SHALL be verified for misalignment: LH 0x101 -> o_ex_ld=1, o_mem_req stays 0, o_stall=0; SW 0x102 -> o_ex_st=1, count unchanged.
REQ-035 SHALL be verified for load extension from memory: bus returns 0x0000_80F0 for LB 0x100 -> o_rd=0xFFFF_FFF0; LHU 0x100 -> o_rd=0x0000_80F0; with ack latency 3, o_rd_valid occurs 4 cycles after the load is presented.
REQ-036 SHALL be verified for reset mid-drain: i_rst=0 during ST_BUS -> next cycle o_mem_req=0, o_sb_empty=1, and a subsequent LW to the same address issues a bus read.
